// File: rtl/rw_port_arbiter.sv
// Two-master arbiter for the shared rw load/store port; grant is combinational and ownership
// is held across stalled transactions (and by M1 while m1_lock is high).
module rw_port_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int STARVE_LIMIT  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [29:0] m0_address,
  input  logic [3:0]  m0_byte_mask,
  input  logic        m0_read_not_write,
  input  logic        m0_active,
  input  logic [31:0] m0_data_in,
  output logic [31:0] m0_data_out,
  output logic        m0_address_valid,
  output logic        m0_wait,
  input  logic [29:0] m1_address,
  input  logic [3:0]  m1_byte_mask,
  input  logic        m1_read_not_write,
  input  logic        m1_active,
  input  logic [31:0] m1_data_in,
  output logic [31:0] m1_data_out,
  output logic        m1_address_valid,
  output logic        m1_wait,
  input  logic        m1_lock,
  output logic [29:0] ds_address,
  output logic [3:0]  ds_byte_mask,
  output logic        ds_read_not_write,
  output logic        ds_active,
  output logic [31:0] ds_data_in,
  input  logic [31:0] ds_data_out,
  input  logic        ds_address_valid,
  input  logic        ds_wait
);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_M0 = 2'd1, OWN_M1 = 2'd2} owner_e;

  localparam logic [7:0] STARVE_LIM8 = STARVE_LIMIT[7:0];

  owner_e      owner_q, owner_d, grant;
  logic        rr_last_m1_q, rr_last_m1_d;
  logic [7:0]  starve_cnt_q, starve_cnt_d;
  logic        g_active;
  logic        complete;

  always_comb begin
    grant = owner_q;
    if (owner_q == OWN_NONE) begin
      if (m0_active && m1_active) begin
        if (PRIORITY_MODE == 0) grant = rr_last_m1_q ? OWN_M0 : OWN_M1;
        else                    grant = (starve_cnt_q >= STARVE_LIM8) ? OWN_M1 : OWN_M0;
      end else if (m0_active) begin
        grant = OWN_M0;
      end else if (m1_active) begin
        grant = OWN_M1;
      end else begin
        grant = OWN_NONE;
      end
    end
  end

  // Idle bus drives a harmless read of address 0; a refused master simply sees wait.
  always_comb begin
    ds_address        = '0;
    ds_byte_mask      = '0;
    ds_read_not_write = 1'b1;
    ds_active         = 1'b0;
    ds_data_in        = '0;
    m0_data_out       = '0;
    m0_address_valid  = 1'b0;
    m0_wait           = m0_active;
    m1_data_out       = '0;
    m1_address_valid  = 1'b0;
    m1_wait           = m1_active;
    g_active          = 1'b0;
    case (grant)
      OWN_M0: begin
        ds_address        = m0_address;
        ds_byte_mask      = m0_byte_mask;
        ds_read_not_write = m0_read_not_write;
        ds_active         = m0_active;
        ds_data_in        = m0_data_in;
        m0_data_out       = ds_data_out;
        m0_address_valid  = ds_address_valid;
        m0_wait           = ds_wait;
        g_active          = m0_active;
      end
      OWN_M1: begin
        ds_address        = m1_address;
        ds_byte_mask      = m1_byte_mask;
        ds_read_not_write = m1_read_not_write;
        ds_active         = m1_active;
        ds_data_in        = m1_data_in;
        m1_data_out       = ds_data_out;
        m1_address_valid  = ds_address_valid;
        m1_wait           = ds_wait;
        g_active          = m1_active;
      end
      default: ;
    endcase
  end

  assign complete = g_active && !ds_wait;

  always_comb begin
    owner_d      = OWN_NONE;
    rr_last_m1_d = rr_last_m1_q;
    starve_cnt_d = starve_cnt_q;
    // A stall claims the port; otherwise only a held M1 lock keeps it.
    if (grant != OWN_NONE) begin
      if (g_active && ds_wait)                  owner_d = grant;
      else if ((grant == OWN_M1) && m1_lock)    owner_d = OWN_M1;
    end
    if (complete) rr_last_m1_d = (grant == OWN_M1);
    if (!m1_active || (complete && (grant == OWN_M1))) begin
      starve_cnt_d = '0;
    end else if ((grant != OWN_M1) && (starve_cnt_q != 8'hFF)) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q      <= OWN_NONE;
      rr_last_m1_q <= 1'b1;
      starve_cnt_q <= '0;
    end else begin
      owner_q      <= owner_d;
      rr_last_m1_q <= rr_last_m1_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: doc/rw_port_arbiter.md
Name: rw_port_arbiter

Overview:
- Shares the single CPU load/store (rw) port of the memory/IO interface between two masters: M0 = CPU load/store unit, M1 = debug/DMA master.
- Sits between both masters and the interface's rw_* port.
- The granted master's request is passed through combinationally; the non-granted master is stalled by forcing its wait high.
- Ownership is held across multi-cycle transactions (RAM reads, TTY busy) so a transaction is never split between masters.

Parameters:
- PRIORITY_MODE, 0, 0 = round-robin; 1 = fixed priority to M0 with M1 anti-starvation.
- STARVE_LIMIT, 16, in fixed mode, number of consecutive cycles M1 may be refused before it wins the next arbitration (1..255).

Ports:
- clk  input  1  clock.
- reset_n  input  1  reset, asynchronous, active-low.
- m0_address, m1_address  input  30  word address [31:2].
- m0_byte_mask, m1_byte_mask  input  4  byte enables.
- m0_read_not_write, m1_read_not_write  input  1  1 = read.
- m0_active, m1_active  input  1  request.
- m0_data_in, m1_data_in  input  32  write data.
- m0_data_out, m1_data_out  output  32  read data, valid when active & ~wait.
- m0_address_valid, m1_address_valid  output  1  downstream address decode result, granted master only.
- m0_wait, m1_wait  output  1  stall.
- m1_lock  input  1  M1 keeps the port across back-to-back transactions while high.
- ds_address  output  30  to interface.
- ds_byte_mask  output  4  to interface.
- ds_read_not_write  output  1  to interface.
- ds_active  output  1  to interface.
- ds_data_in  output  32  to interface.
- ds_data_out  input  32  from interface.
- ds_address_valid  input  1  from interface.
- ds_wait  input  1  from interface.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- State owner ∈ {NONE, M0, M1} (registered).
- rr_last (registered): the master served last.
- starve_cnt: 8-bit, saturating.
- Effective grant g:
  - g = owner if owner ≠ NONE.
  - Otherwise g is chosen combinationally from the current mN_active:
    - Single requester wins.
    - Both requesting, round-robin: the master ≠ rr_last wins.
    - Both requesting, fixed: M0 wins unless starve_cnt ≥ STARVE_LIMIT.
    - No requester: g = NONE.
- Pass-through for g = Mx:
  - ds_* request signals = mx_*.
  - mx_wait = ds_wait; mx_data_out = ds_data_out; mx_address_valid = ds_address_valid.
- Non-granted master: wait = 1 whenever its active = 1, else wait = 0; address_valid = 0; data_out = 0.
- g = NONE: ds_active = 0, ds_address = 0, ds_byte_mask = 0, ds_read_not_write = 1, ds_data_in = 0.
- Completion = g ≠ NONE & mg_active & ~ds_wait. On completion:
  - rr_last ← g.
  - owner ← NONE, except owner ← M1 if g = M1 & m1_lock.
- Stall = mg_active & ds_wait → owner ← g. Zero added latency; a RAM write with ds_wait = 0 never sets owner.
- Abort: granted master drops active while owner = g → owner ← NONE next cycle. No downstream cleanup; the interface's ignore cycle absorbs it.
- m1_lock while owner = M1 and m1_active = 0: owner held; M0 stalled.
- starve_cnt:
  - Increments when m1_active & g ≠ M1; saturates at 255.
  - Cleared on M1 completion or when m1_active = 0.
  - Only consulted in fixed mode.
- Reset (asynchronous, anytime including mid-transaction): owner = NONE, rr_last = M1 (so M0 wins the first tie), starve_cnt = 0.
- Output values during reset follow the combinational rules, given owner = NONE.
- Arbitration never changes g while owner ≠ NONE, even if the other master asserts active in the same cycle.

Test Plan:
1. M0 read only (ds_wait = 1 for 1 cycle, then 0, ds_data_out = 32'h1234_5678): ds_active follows m0_active with 0 added latency; m0_data_out = 32'h1234_5678 on the completion cycle; m1_wait = 0 throughout.
2. Both masters raise active in the same cycle after reset, round-robin, each read stalls 1 cycle: M0 served first; M1 is granted the cycle after M0 completes; m1_wait = 1 until then; grants alternate M0, M1, M0 over 3 transactions each.
3. M1 write to the TTY address with ds_wait = 1 for 5 cycles; M0 requests during cycle 2:
   - owner stays M1.
   - ds_address stays M1's address for all 5 cycles.
   - M0 is granted the cycle after M1 completes.
4. PRIORITY_MODE = 1, STARVE_LIMIT = 4, M0 continuously issuing 1-cycle RAM writes, M1 requesting: M1 is granted on the 5th cycle of its request; starve_cnt returns to 0 after M1 completes.
5. m1_lock = 1 across 3 M1 transactions while M0 requests: M0 sees wait = 1 until m1_lock falls and the current M1 transaction completes; then M0 is granted.
6. reset_n pulsed low mid M0 stalled read: owner → NONE immediately (asynchronous); after release with both requesting, M0 wins; ds_active = 0 while neither master requests.
